// File: rtl/t03_combat_resolver.sv
// -----------------------------------------------------------------------------
// t03_combat_resolver
//
// Purpose:
//   Resolves combat between two players. On each frame strobe it samples
//   both players' 2-bit action states, detects the rising start of an attack
//   (01 now, not 01 on the previous frame), applies damage to the opponent
//   (reduced when the opponent is blocking), tracks both health bars with
//   saturation at zero, and declares game over and the winner.
//
// Ports:
//   clk        in   1         system clock
//   rst        in   1         asynchronous active-high reset
//   finished   in   1         frame strobe; qualifies every state update
//   p1_state   in   2         P1 action: 00 rest, 01 attack, 10 block, 11 (rest)
//   p2_state   in   2         P2 action, same encoding
//   in_range   in   1         players close enough for an attack to connect
//   restart    in   1         new-round request, sampled with finished
//   p1_health  out  HEALTH_W  P1 remaining health
//   p2_health  out  HEALTH_W  P2 remaining health
//   p1_hit     out  1         one-cycle pulse: P1 took damage
//   p2_hit     out  1         one-cycle pulse: P2 took damage
//   game_over  out  1         round has ended
//   winner     out  2         00 none, 01 P1, 10 P2, 11 draw
// -----------------------------------------------------------------------------
module t03_combat_resolver #(
    parameter int unsigned         HEALTH_W       = 7,
    parameter logic [HEALTH_W-1:0] START_HEALTH   = 7'd100,
    parameter logic [HEALTH_W-1:0] ATTACK_DAMAGE  = 7'd10,
    parameter logic [HEALTH_W-1:0] BLOCKED_DAMAGE = 7'd2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                finished,
    input  logic [1:0]          p1_state,
    input  logic [1:0]          p2_state,
    input  logic                in_range,
    input  logic                restart,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_hit,
    output logic                p2_hit,
    output logic                game_over,
    output logic [1:0]          winner
);

    typedef enum logic [1:0] {
        ACT_REST   = 2'b00,
        ACT_ATTACK = 2'b01,
        ACT_BLOCK  = 2'b10,
        ACT_ILLEGAL = 2'b11
    } action_e;

    typedef enum logic {
        S_PLAY,
        S_GAME_OVER
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            p1_prev_q, p1_prev_d;
    logic [1:0]            p2_prev_q, p2_prev_d;
    logic [HEALTH_W-1:0]   p1_health_q, p1_health_d;
    logic [HEALTH_W-1:0]   p2_health_q, p2_health_d;
    logic                  p1_hit_q, p1_hit_d;
    logic                  p2_hit_q, p2_hit_d;
    logic                  game_over_q, game_over_d;
    logic [1:0]            winner_q, winner_d;

    logic                  p1_atk_start;
    logic                  p2_atk_start;
    logic [HEALTH_W-1:0]   dmg_to_p1;
    logic [HEALTH_W-1:0]   dmg_to_p2;

    function automatic logic [HEALTH_W-1:0] sat_sub(
        input logic [HEALTH_W-1:0] h,
        input logic [HEALTH_W-1:0] d
    );
        return (h > d) ? (h - d) : '0;
    endfunction

    // Edge detect against the previous frame's sample so a held attack
    // lands only once. State 11 never matches attack or block.
    assign p1_atk_start = (p1_state == ACT_ATTACK) && (p1_prev_q != ACT_ATTACK);
    assign p2_atk_start = (p2_state == ACT_ATTACK) && (p2_prev_q != ACT_ATTACK);

    // Damage uses the opponent's current (pre-update) state, so simultaneous
    // attack starts resolve independently of each other.
    assign dmg_to_p2 = (p2_state == ACT_BLOCK) ? BLOCKED_DAMAGE : ATTACK_DAMAGE;
    assign dmg_to_p1 = (p1_state == ACT_BLOCK) ? BLOCKED_DAMAGE : ATTACK_DAMAGE;

    always_comb begin
        state_d     = state_q;
        p1_prev_d   = p1_prev_q;
        p2_prev_d   = p2_prev_q;
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_hit_d    = 1'b0;
        p2_hit_d    = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        if (finished) begin
            p1_prev_d = p1_state;
            p2_prev_d = p2_state;

            if (restart) begin
                // Restart wins over any attack start on the same frame.
                state_d     = S_PLAY;
                p1_health_d = START_HEALTH;
                p2_health_d = START_HEALTH;
                game_over_d = 1'b0;
                winner_d    = 2'b00;
            end else if (state_q == S_PLAY) begin
                if (p1_atk_start && in_range) begin
                    p2_health_d = sat_sub(p2_health_q, dmg_to_p2);
                    p2_hit_d    = (p2_health_d != p2_health_q);
                end
                if (p2_atk_start && in_range) begin
                    p1_health_d = sat_sub(p1_health_q, dmg_to_p1);
                    p1_hit_d    = (p1_health_d != p1_health_q);
                end
                if ((p1_health_d == '0) || (p2_health_d == '0)) begin
                    state_d     = S_GAME_OVER;
                    game_over_d = 1'b1;
                    // bit1: P2 wins (P1 dead), bit0: P1 wins (P2 dead).
                    winner_d    = {p1_health_d == '0, p2_health_d == '0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_PLAY;
            p1_prev_q   <= 2'b00;
            p2_prev_q   <= 2'b00;
            p1_health_q <= START_HEALTH;
            p2_health_q <= START_HEALTH;
            p1_hit_q    <= 1'b0;
            p2_hit_q    <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            p1_prev_q   <= p1_prev_d;
            p2_prev_q   <= p2_prev_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_hit_q    <= p1_hit_d;
            p2_hit_q    <= p2_hit_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign p1_health = p1_health_q;
    assign p2_health = p2_health_q;
    assign p1_hit    = p1_hit_q;
    assign p2_hit    = p2_hit_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule

// File: tb/tb_t03_combat_resolver.sv
// -----------------------------------------------------------------------------
// tb_t03_combat_resolver
//
// Table of frame-by-frame stimulus records with expected outputs, applied in
// order from reset; each record's expectation goes into a scoreboard queue
// and is compared one step after the sampling edge. Reset behaviour is
// exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_t03_combat_resolver;

    typedef struct packed {
        logic [6:0] p1h;
        logic [6:0] p2h;
        logic       p1hit;
        logic       p2hit;
        logic       go;
        logic [1:0] win;
    } out_t;

    typedef struct {
        logic       fin;
        logic       rs;
        logic [1:0] p1;
        logic [1:0] p2;
        logic       rng;
        out_t       exp;
        string      name;
    } vec_t;

    typedef struct {
        out_t  exp;
        string name;
    } sb_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       finished = 1'b0;
    logic [1:0] p1_state = 2'b00;
    logic [1:0] p2_state = 2'b00;
    logic       in_range = 1'b0;
    logic       restart = 1'b0;
    logic [6:0] p1_health;
    logic [6:0] p2_health;
    logic       p1_hit;
    logic       p2_hit;
    logic       game_over;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];
    sb_t  sb_q[$];

    t03_combat_resolver #(
        .HEALTH_W(7),
        .START_HEALTH(7'd100),
        .ATTACK_DAMAGE(7'd10),
        .BLOCKED_DAMAGE(7'd2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .finished(finished),
        .p1_state(p1_state),
        .p2_state(p2_state),
        .in_range(in_range),
        .restart(restart),
        .p1_health(p1_health),
        .p2_health(p2_health),
        .p1_hit(p1_hit),
        .p2_hit(p2_hit),
        .game_over(game_over),
        .winner(winner)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input int h1, input int h2, input int hit1,
                                input int hit2, input int go, input int win);
        out_t o;
        o.p1h   = 7'(h1);
        o.p2h   = 7'(h2);
        o.p1hit = 1'(hit1);
        o.p2hit = 1'(hit2);
        o.go    = 1'(go);
        o.win   = 2'(win);
        return o;
    endfunction

    task automatic add(input string name, input int fin, input int rs,
                       input int p1, input int p2, input int rng,
                       input int h1, input int h2, input int hit1,
                       input int hit2, input int go, input int win);
        vec_t v;
        v.name = name;
        v.fin  = 1'(fin);
        v.rs   = 1'(rs);
        v.p1   = 2'(p1);
        v.p2   = 2'(p2);
        v.rng  = 1'(rng);
        v.exp  = mk(h1, h2, hit1, hit2, go, win);
        vecs.push_back(v);
    endtask

    function automatic out_t dut_out();
        out_t o;
        o.p1h   = p1_health;
        o.p2h   = p2_health;
        o.p1hit = p1_hit;
        o.p2hit = p2_hit;
        o.go    = game_over;
        o.win   = winner;
        return o;
    endfunction

    task automatic compare(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got p1h=%0d p2h=%0d p1hit=%b p2hit=%b go=%b win=%b, want p1h=%0d p2h=%0d p1hit=%b p2hit=%b go=%b win=%b",
                     name, got.p1h, got.p2h, got.p1hit, got.p2hit, got.go, got.win,
                     exp.p1h, exp.p2h, exp.p1hit, exp.p2hit, exp.go, exp.win);
        end
    endtask

    // Drive one frame at the falling edge; expectation is scored after the
    // following rising edge by the monitor below.
    task automatic step(input vec_t v);
        sb_t s;
        @(negedge clk);
        finished = v.fin;
        restart  = v.rs;
        p1_state = v.p1;
        p2_state = v.p2;
        in_range = v.rng;
        s.exp  = v.exp;
        s.name = v.name;
        sb_q.push_back(s);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            compare(s.name, dut_out(), s.exp);
        end
    end

    initial begin
        vec_t v;

        // Round 1: basic hit, hold, block, range, strobe qualification.
        add("hit1",      1,0,1,0,1, 100,90,0,1,0,0);
        add("pulse_clr", 0,0,1,0,1, 100,90,0,0,0,0);
        for (int i = 0; i < 50; i++)
            add("hold",  1,0,1,0,1, 100,90,0,0,0,0);
        add("rel",       1,0,0,0,1, 100,90,0,0,0,0);
        add("blk_hit",   1,0,1,2,1, 100,88,0,1,0,0);
        add("rel",       1,0,0,2,1, 100,88,0,0,0,0);
        add("out_range", 1,0,1,0,0, 100,88,0,0,0,0);
        add("rel",       1,0,0,0,1, 100,88,0,0,0,0);
        add("nofin_a",   0,0,1,0,1, 100,88,0,0,0,0);
        add("nofin_b",   0,0,0,0,1, 100,88,0,0,0,0);
        add("nofin_c",   0,0,1,0,1, 100,88,0,0,0,0);
        add("fin_hit",   1,0,1,0,1, 100,78,0,1,0,0);
        add("rel",       1,0,0,0,1, 100,78,0,0,0,0);
        add("ill_opp",   1,0,3,1,1,  90,78,1,0,0,0);
        add("rel",       1,0,0,0,1,  90,78,0,0,0,0);
        add("p1_block",  1,0,2,1,1,  88,78,1,0,0,0);
        add("rel",       1,0,0,0,1,  88,78,0,0,0,0);
        for (int k = 1; k <= 7; k++) begin
            add("grind", 1,0,1,0,1,  88,78-10*k,0,1,0,0);
            add("rel",   1,0,0,0,1,  88,78-10*k,0,0,0,0);
        end
        add("blk_low",   1,0,1,2,1,  88,6,0,1,0,0);
        add("rel",       1,0,0,0,1,  88,6,0,0,0,0);
        add("ko_sat",    1,0,1,0,1,  88,0,0,1,1,1);
        add("frozen",    1,0,0,0,1,  88,0,0,0,1,1);
        add("go_attack", 1,0,1,1,1,  88,0,0,0,1,1);
        add("rel",       1,0,0,0,1,  88,0,0,0,1,1);
        add("restart",   1,1,1,0,1, 100,100,0,0,0,0);
        add("held_post", 1,0,1,0,1, 100,100,0,0,0,0);
        add("rel",       1,0,0,0,1, 100,100,0,0,0,0);
        // Round 2: mutual hits down to a draw.
        for (int k = 1; k <= 9; k++) begin
            add("mutual",1,0,1,1,1, 100-10*k,100-10*k,1,1,0,0);
            add("rel",   1,0,0,0,1, 100-10*k,100-10*k,0,0,0,0);
        end
        add("draw",      1,0,1,1,1,   0,0,1,1,1,3);
        add("frozen_d",  1,0,0,0,1,   0,0,0,0,1,3);
        add("rs_nofin",  0,1,0,0,1,   0,0,0,0,1,3);
        add("restart2",  1,1,0,0,1, 100,100,0,0,0,0);
        add("hit_r2",    1,0,1,0,1, 100,90,0,1,0,0);

        // Power-on reset values.
        repeat (2) @(posedge clk);
        #2;
        compare("reset_vals", dut_out(), mk(100,100,0,0,0,0));
        @(posedge clk);
        #3 rst = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Mid-round async reset with P1 held at attack: values return at once,
        // then the held attack counts once after release (prev cleared).
        @(negedge clk);
        #2 rst = 1'b1;
        #1 compare("mid_reset", dut_out(), mk(100,100,0,0,0,0));
        @(posedge clk);
        #3 rst = 1'b0;
        v.fin = 1'b1; v.rs = 1'b0; v.p1 = 2'b01; v.p2 = 2'b00; v.rng = 1'b1;
        v.exp = mk(100,90,0,1,0,0); v.name = "held_thru_rst";
        step(v);
        v.exp = mk(100,90,0,0,0,0); v.name = "held_once";
        step(v);

        // Drain the scoreboard with a bounded wait.
        for (int n = 0; n < 5 && sb_q.size() > 0; n++) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
